ysyx_25040111_ifu: RTL and testbench

Multicycle instruction fetch unit that sits directly upstream of the IDU.
- Holds the PC and issues one instruction-memory read per instruction over a valid/ready request channel.
- Captures the response word and presents {pc, inst} to the IDU over a valid/ready handshake.
- Waits for the commit-stage next-PC before starting the next fetch.
- Keeps a retired-fetch counter for the performance/difftest hooks.

---
 rtl/ysyx_25040111_ifu_if.sv | 35 +++
 rtl/ysyx_25040111_ifu.sv | 99 +++++++++
 tb/tb_ysyx_25040111_ifu.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040111_ifu_if.sv
// Handshake bundle between the IFU, instruction memory, IDU and commit stage.
// The master modport is the IFU side.
interface ysyx_25040111_ifu_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        fetch_err;
  logic        npc_valid;
  logic [31:0] npc;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    output inst_valid, inst, pc, fetch_err,
    input  inst_ready,
    input  npc_valid, npc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    input  inst_valid, inst, pc, fetch_err,
    output inst_ready,
    output npc_valid, npc
  );
endinterface

// File: rtl/ysyx_25040111_ifu.sv
// Multicycle instruction fetch unit: one memory read per instruction, then
// hands {pc, inst, fetch_err} to the IDU and waits for the commit-stage npc.
//
// state | meaning
// BOOT  | first cycle after reset, no handshakes
// REQ   | read request to memory held until accepted
// WAIT  | waiting for the read response
// DELIV | instruction presented to the IDU
// NEXT  | waiting for the next PC from commit
module ysyx_25040111_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned CNT_W    = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ysyx_25040111_ifu_if.master    bus,
  output logic [CNT_W-1:0]       inst_cnt
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DELIV = 3'd3,
    S_NEXT  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ: begin
        if (bus.mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mem_rsp_valid) begin
          inst_d  = bus.mem_rsp_data;
          err_d   = bus.mem_rsp_err;
          state_d = S_DELIV;
        end
      end
      S_DELIV: begin
        if (bus.inst_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (bus.npc_valid) begin
          pc_d = bus.npc;
          if (bus.npc[1:0] == 2'b00) begin
            state_d = S_REQ;
          end else begin
            // Misaligned target: report the fault without touching the bus.
            inst_d  = 32'h0;
            err_d   = 1'b1;
            state_d = S_DELIV;
          end
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign bus.mem_req_valid = (state_q == S_REQ);
  assign bus.mem_req_addr  = pc_q;
  assign bus.inst_valid    = (state_q == S_DELIV);
  assign bus.inst          = inst_q;
  assign bus.pc            = pc_q;
  assign bus.fetch_err     = err_q;
  assign inst_cnt          = cnt_q;

endmodule

// File: tb/tb_ysyx_25040111_ifu.sv
// Bench for ysyx_25040111_ifu: table of fetch vectors plus a reset-in-WAIT sequence,
// with a queue scoreboard matching accepted requests to delivered instructions.
module tb_ysyx_25040111_ifu;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          CNT_W    = 64;

  typedef struct {
    logic [31:0] exp_pc;
    logic [31:0] rsp_data;
    logic        rsp_err;
    int          req_stall;
    int          rdy_stall;
    logic [31:0] npc;
    logic [31:0] trap_npc;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
  } sb_t;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] inst_cnt;
  ysyx_25040111_ifu_if bus ();

  ysyx_25040111_ifu #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.master),
    .inst_cnt (inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_cnt;
  sb_t         sb[$];
  vec_t        vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_check();
    sb_t e;
    chk("inst_valid_up", 64'(bus.inst_valid), 64'd1);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got delivery with no expected entry at %0t", $time);
    end else begin
      e = sb.pop_front();
      chk("sb_pc", 64'(bus.pc), 64'(e.pc));
      chk("sb_inst", 64'(bus.inst), 64'(e.inst));
      chk("sb_err", 64'(bus.fetch_err), 64'(e.err));
    end
  endtask

  // Called at a negedge with the DUT expected in REQ.
  task automatic run_vec(input vec_t v);
    chk("req_valid", 64'(bus.mem_req_valid), 64'd1);
    chk("req_addr", 64'(bus.mem_req_addr), 64'(v.exp_pc));
    for (int i = 0; i < v.req_stall; i++) begin
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hBAD0_0000;
      @(negedge clk);
      chk("req_hold_valid", 64'(bus.mem_req_valid), 64'd1);
      chk("req_hold_addr", 64'(bus.mem_req_addr), 64'(v.exp_pc));
    end
    bus.mem_rsp_valid = 1'b0;
    bus.mem_req_ready = 1'b1;
    sb.push_back('{pc: v.exp_pc, inst: v.exp_inst, err: v.exp_err});
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk("req_single", 64'(bus.mem_req_valid), 64'd0);
    chk("wait_no_inst", 64'(bus.inst_valid), 64'd0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = v.rsp_data;
    bus.mem_rsp_err   = v.rsp_err;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_err   = 1'b0;
    sb_check();
    for (int i = 0; i < v.rdy_stall; i++) begin
      bus.inst_ready    = 1'b0;
      bus.npc_valid     = 1'b1;
      bus.npc           = 32'h1234_5678;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = ~v.rsp_data;
      @(negedge clk);
      chk("deliv_hold_valid", 64'(bus.inst_valid), 64'd1);
      chk("deliv_hold_pc", 64'(bus.pc), 64'(v.exp_pc));
      chk("deliv_hold_inst", 64'(bus.inst), 64'(v.exp_inst));
      chk("deliv_hold_err", 64'(bus.fetch_err), 64'(v.exp_err));
      chk("deliv_hold_cnt", inst_cnt, model_cnt);
    end
    bus.npc_valid     = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.inst_ready    = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    model_cnt++;
    chk("inst_cnt", inst_cnt, model_cnt);
    chk("inst_valid_down", 64'(bus.inst_valid), 64'd0);
    bus.npc_valid = 1'b1;
    bus.npc       = v.npc;
    @(negedge clk);
    bus.npc_valid = 1'b0;
    if (v.npc[1:0] != 2'b00) begin
      chk("misalign_no_req", 64'(bus.mem_req_valid), 64'd0);
      sb.push_back('{pc: v.npc, inst: 32'h0, err: 1'b1});
      sb_check();
      bus.inst_ready = 1'b1;
      @(negedge clk);
      bus.inst_ready = 1'b0;
      model_cnt++;
      chk("misalign_cnt", inst_cnt, model_cnt);
      bus.npc_valid = 1'b1;
      bus.npc       = v.trap_npc;
      @(negedge clk);
      bus.npc_valid = 1'b0;
    end
  endtask

  initial begin
    //          exp_pc         rsp_data      err  rq  rd  npc            trap_npc       exp_inst      exp_err
    vecs[0] = '{32'h8000_0000, 32'h0010_0093, 1'b0, 0, 0, 32'h8000_0004, 32'h0,         32'h0010_0093, 1'b0};
    vecs[1] = '{32'h8000_0004, 32'h0020_0113, 1'b0, 5, 0, 32'h8000_0008, 32'h0,         32'h0020_0113, 1'b0};
    vecs[2] = '{32'h8000_0008, 32'h0030_8193, 1'b0, 0, 3, 32'h8000_000C, 32'h0,         32'h0030_8193, 1'b0};
    vecs[3] = '{32'h8000_000C, 32'hDEAD_BEEF, 1'b1, 0, 0, 32'h8000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1};
    vecs[4] = '{32'h8000_0010, 32'h0000_0013, 1'b0, 1, 1, 32'h8000_0100, 32'h0,         32'h0000_0013, 1'b0};
    vecs[5] = '{32'h8000_0100, 32'h0000_0073, 1'b0, 0, 0, 32'h8000_0102, 32'h8000_0200, 32'h0000_0073, 1'b0};
    vecs[6] = '{32'h8000_0200, 32'h0040_0213, 1'b0, 0, 0, 32'h8000_0204, 32'h0,         32'h0040_0213, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h0050_0293, 1'b0, 0, 0, 32'h8000_0004, 32'h0,         32'h0050_0293, 1'b0};

    model_cnt         = '0;
    rst_n             = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = 32'h0;
    bus.mem_rsp_err   = 1'b0;
    bus.inst_ready    = 1'b0;
    bus.npc_valid     = 1'b0;
    bus.npc           = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_pc", 64'(bus.pc), 64'(RESET_PC));
    chk("rst_inst", 64'(bus.inst), 64'd0);
    chk("rst_err", 64'(bus.fetch_err), 64'd0);
    chk("rst_cnt", inst_cnt, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Start a fetch at the trap vector, then reset while the response is pending.
    chk("pre_rst_req", 64'(bus.mem_req_valid), 64'd1);
    chk("pre_rst_addr", 64'(bus.mem_req_addr), 64'(vecs[6].exp_pc));
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("mid_rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("mid_rst_pc", 64'(bus.pc), 64'(RESET_PC));
    chk("mid_rst_err", 64'(bus.fetch_err), 64'd0);
    chk("mid_rst_cnt", inst_cnt, 64'd0);
    @(negedge clk);
    rst_n             = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hBAD0_BAD0;
    bus.mem_rsp_err   = 1'b1;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_err   = 1'b0;
    chk("stray_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("stray_inst", 64'(bus.inst), 64'd0);
    chk("stray_err", 64'(bus.fetch_err), 64'd0);
    model_cnt = '0;
    sb.delete();
    run_vec(vecs[7]);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete at %0t", $time);
    $fatal(1);
  end
endmodule
